// File: rtl/mdu.sv
// ============================================================================
// Module      : mdu
// Description : E-stage multiply/divide unit that owns the HI/LO registers.
//               It runs mult/multu/div/divu over a fixed busy window, and
//               handles mthi/mtlo writes and mfhi/mflo reads.
//               Optional feature macro: MDU_CANCEL_EN adds a cancel input
//               that aborts an in-flight operation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
`ifdef MDU_CANCEL_EN
    input  logic        cancel,
`endif
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    output logic        busy,
    output logic [31:0] read_data,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] c_OP_MULT  = 4'd1;
    localparam logic [3:0] c_OP_MULTU = 4'd2;
    localparam logic [3:0] c_OP_DIV   = 4'd3;
    localparam logic [3:0] c_OP_DIVU  = 4'd4;
    localparam logic [3:0] c_OP_MFHI  = 4'd5;
    localparam logic [3:0] c_OP_MFLO  = 4'd6;
    localparam logic [3:0] c_OP_MTHI  = 4'd7;
    localparam logic [3:0] c_OP_MTLO  = 4'd8;

    localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);

    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic               r_busy;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_op1;
    logic [31:0]        r_op2;
    logic [3:0]         r_op;

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_neg1;
    logic        w_neg2;
    logic        w_div_zero;
    logic [31:0] w_abs1;
    logic [31:0] w_abs2;
    logic [31:0] w_dsor_s;
    logic [31:0] w_dsor_u;
    logic [31:0] w_uq_s;
    logic [31:0] w_ur_s;
    logic [31:0] w_q_s;
    logic [31:0] w_r_s;
    logic [31:0] w_q_u;
    logic [31:0] w_r_u;

    // Products use explicit 64-bit extension so the low 64 bits are exact.
    assign w_prod_s = {{32{r_op1[31]}}, r_op1} * {{32{r_op2[31]}}, r_op2};
    assign w_prod_u = {32'd0, r_op1} * {32'd0, r_op2};

    // Signed divide on magnitudes avoids the INT_MIN / -1 overflow corner.
    assign w_neg1     = r_op1[31];
    assign w_neg2     = r_op2[31];
    assign w_abs1     = w_neg1 ? (32'd0 - r_op1) : r_op1;
    assign w_abs2     = w_neg2 ? (32'd0 - r_op2) : r_op2;
    assign w_div_zero = (r_op2 == 32'd0);
    assign w_dsor_s   = w_div_zero ? 32'd1 : w_abs2;
    assign w_dsor_u   = w_div_zero ? 32'd1 : r_op2;
    assign w_uq_s     = w_abs1 / w_dsor_s;
    assign w_ur_s     = w_abs1 % w_dsor_s;
    assign w_q_s      = (w_neg1 ^ w_neg2) ? (32'd0 - w_uq_s) : w_uq_s;
    assign w_r_s      = w_neg1 ? (32'd0 - w_ur_s) : w_ur_s;
    assign w_q_u      = r_op1 / w_dsor_u;
    assign w_r_u      = r_op1 % w_dsor_u;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_op1  <= 32'd0;
            r_op2  <= 32'd0;
            r_op   <= 4'd0;
        end
`ifdef MDU_CANCEL_EN
        else if (cancel) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end
`endif
        else if (r_busy) begin
            if (r_cnt == c_CNT_W'(1)) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
                case (r_op)
                    c_OP_MULT:  {r_hi, r_lo} <= w_prod_s;
                    c_OP_MULTU: {r_hi, r_lo} <= w_prod_u;
                    c_OP_DIV: begin
                        if (!w_div_zero) begin
                            r_lo <= w_q_s;
                            r_hi <= w_r_s;
                        end
                    end
                    c_OP_DIVU: begin
                        if (!w_div_zero) begin
                            r_lo <= w_q_u;
                            r_hi <= w_r_u;
                        end
                    end
                    default: ;
                endcase
            end else begin
                r_cnt <= r_cnt - c_CNT_W'(1);
            end
        end else if (start) begin
            case (op)
                c_OP_MULT, c_OP_MULTU: begin
                    r_op1  <= operand1;
                    r_op2  <= operand2;
                    r_op   <= op;
                    r_cnt  <= c_CNT_W'(MULT_CYCLES);
                    r_busy <= 1'b1;
                end
                c_OP_DIV, c_OP_DIVU: begin
                    r_op1  <= operand1;
                    r_op2  <= operand2;
                    r_op   <= op;
                    r_cnt  <= c_CNT_W'(DIV_CYCLES);
                    r_busy <= 1'b1;
                end
                c_OP_MTHI: r_hi <= operand1;
                c_OP_MTLO: r_lo <= operand1;
                default: ;
            endcase
        end
    end

    always_comb begin
        read_data = 32'd0;
        if (op == c_OP_MFHI)
            read_data = r_hi;
        else if (op == c_OP_MFLO)
            read_data = r_lo;
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

`default_nettype wire
